// File: rtl/regfile_port_arbiter_if.sv
// Bundle between two register-file clients, the port arbiter and the 32x32 register file.
// The slave modport is the arbiter's view. The master modport is the clients' and file's view.
interface regfile_port_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_we;
    logic [AW-1:0] req0_ra1;
    logic [AW-1:0] req0_ra2;
    logic [AW-1:0] req0_wa;
    logic [DW-1:0] req0_wd;
    logic          req1_valid;
    logic          req1_ready;
    logic          req1_we;
    logic [AW-1:0] req1_ra1;
    logic [AW-1:0] req1_ra2;
    logic [AW-1:0] req1_wa;
    logic [DW-1:0] req1_wd;
    logic          rsp0_valid;
    logic          rsp0_ready;
    logic          rsp1_valid;
    logic          rsp1_ready;
    logic [DW-1:0] rsp_rd1;
    logic [DW-1:0] rsp_rd2;
    logic          busy;
    logic [AW-1:0] rf_r1_addr;
    logic [AW-1:0] rf_r2_addr;
    logic [AW-1:0] rf_r3_addr;
    logic [DW-1:0] rf_r3_din;
    logic          rf_r3_wr;
    logic [DW-1:0] rf_r1_dout;
    logic [DW-1:0] rf_r2_dout;

    modport slave (
        input  req0_valid, req0_we, req0_ra1, req0_ra2, req0_wa, req0_wd,
        input  req1_valid, req1_we, req1_ra1, req1_ra2, req1_wa, req1_wd,
        input  rsp0_ready, rsp1_ready, rf_r1_dout, rf_r2_dout,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rd1, rsp_rd2,
        output busy, rf_r1_addr, rf_r2_addr, rf_r3_addr, rf_r3_din, rf_r3_wr
    );

    modport master (
        output req0_valid, req0_we, req0_ra1, req0_ra2, req0_wa, req0_wd,
        output req1_valid, req1_we, req1_ra1, req1_ra2, req1_wa, req1_wd,
        output rsp0_ready, rsp1_ready, rf_r1_dout, rf_r2_dout,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rd1, rsp_rd2,
        input  busy, rf_r1_addr, rf_r2_addr, rf_r3_addr, rf_r3_din, rf_r3_wr
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter and sequencer that shares the register file's single port set between two clients.
// Commands are strictly serialized, so a read observes every write accepted before it.
module regfile_port_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    regfile_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        RESP  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t        state_q;
    logic          last_q;
    logic          grant_q;
    logic [AW-1:0] ra1_q;
    logic [AW-1:0] ra2_q;
    logic [AW-1:0] wa_q;
    logic [DW-1:0] wd_q;
    logic          rf_wr_q;
    logic          rsp0_valid_q;
    logic          rsp1_valid_q;
    logic          busy_q;

    logic          accept_s;
    logic          grant_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_ra1_s;
    logic [AW-1:0] sel_ra2_s;
    logic [AW-1:0] sel_wa_s;
    logic [DW-1:0] sel_wd_s;
    logic          rsp_ready_s;

    // Pick the requester to accept this cycle. On a tie, the requester not served last wins.
    always_comb begin
        accept_s = 1'b0;
        grant_s  = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                accept_s = 1'b1;
                grant_s  = ~last_q;
            end else if (bus.req0_valid) begin
                accept_s = 1'b1;
                grant_s  = 1'b0;
            end else if (bus.req1_valid) begin
                accept_s = 1'b1;
                grant_s  = 1'b1;
            end else begin
                accept_s = 1'b0;
                grant_s  = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
            grant_s  = 1'b0;
        end
    end

    // Select the command fields of the winning requester and the response handshake of the owner.
    always_comb begin
        sel_we_s    = bus.req0_we;
        sel_ra1_s   = bus.req0_ra1;
        sel_ra2_s   = bus.req0_ra2;
        sel_wa_s    = bus.req0_wa;
        sel_wd_s    = bus.req0_wd;
        rsp_ready_s = bus.rsp0_ready;
        if (grant_s) begin
            sel_we_s  = bus.req1_we;
            sel_ra1_s = bus.req1_ra1;
            sel_ra2_s = bus.req1_ra2;
            sel_wa_s  = bus.req1_wa;
            sel_wd_s  = bus.req1_wd;
        end else begin
            sel_we_s  = bus.req0_we;
            sel_ra1_s = bus.req0_ra1;
            sel_ra2_s = bus.req0_ra2;
            sel_wa_s  = bus.req0_wa;
            sel_wd_s  = bus.req0_wd;
        end
        if (grant_q) begin
            rsp_ready_s = bus.rsp1_ready;
        end else begin
            rsp_ready_s = bus.rsp0_ready;
        end
    end

    // Sequencer FSM with the command register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            grant_q      <= 1'b0;
            ra1_q        <= {AW{1'b0}};
            ra2_q        <= {AW{1'b0}};
            wa_q         <= {AW{1'b0}};
            wd_q         <= {DW{1'b0}};
            rf_wr_q      <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        grant_q <= grant_s;
                        last_q  <= grant_s;
                        ra1_q   <= sel_ra1_s;
                        ra2_q   <= sel_ra2_s;
                        wa_q    <= sel_wa_s;
                        wd_q    <= sel_wd_s;
                        busy_q  <= 1'b1;
                        if (sel_we_s) begin
                            state_q <= WRITE;
                            // A write to $zero is accepted but never reaches the file.
                            rf_wr_q <= (sel_wa_s != {AW{1'b0}});
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    state_q      <= RESP;
                    rsp0_valid_q <= ~grant_q;
                    rsp1_valid_q <= grant_q;
                end
                RESP: begin
                    if (rsp_ready_s) begin
                        state_q      <= IDLE;
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                    rf_wr_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    rf_wr_q      <= 1'b0;
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ready = accept_s & ~grant_s;
    assign bus.req1_ready = accept_s & grant_s;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.busy       = busy_q;
    assign bus.rf_r1_addr = ra1_q;
    assign bus.rf_r2_addr = ra2_q;
    assign bus.rf_r3_addr = wa_q;
    assign bus.rf_r3_din  = wd_q;
    assign bus.rf_r3_wr   = rf_wr_q;
    assign bus.rsp_rd1    = bus.rf_r1_dout;
    assign bus.rsp_rd2    = bus.rf_r2_dout;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter: a vector table of single transactions
// plus hand-written tie, backpressure, reset-in-RESP and read-after-write sequences.
module tb_regfile_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        int          req;
        logic        we;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass = 0;
    vec_t vecs[8];
    vec_t v_tmp;
    logic [DW-1:0] rf_mem [32];

    always #5 clk = ~clk;

    regfile_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    regfile_port_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file model: registered read ports that latch only while r3_wr is low.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h0;
            bus.rf_r1_dout <= 32'h0;
            bus.rf_r2_dout <= 32'h0;
        end else if (bus.rf_r3_wr) begin
            rf_mem[bus.rf_r3_addr] <= bus.rf_r3_din;
        end else begin
            bus.rf_r1_dout <= rf_mem[bus.rf_r1_addr];
            bus.rf_r2_dout <= rf_mem[bus.rf_r2_addr];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    endtask

    task automatic drive_req(input int r, input logic v, input logic we, input logic [4:0] ra1,
                             input logic [4:0] ra2, input logic [4:0] wa, input logic [31:0] wd);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_ra1 = ra1;
            bus.req0_ra2 = ra2; bus.req0_wa = wa; bus.req0_wd = wd;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_ra1 = ra1;
            bus.req1_ra2 = ra2; bus.req1_wa = wa; bus.req1_wd = wd;
        end
    endtask

    function automatic logic ready_of(input int r);
        return (r == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic rspv_of(input int r);
        return (r == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction

    // One transaction from a single requester with full latency checks.
    task automatic run_vec(input int idx, input vec_t v);
        int o;
        o = 1 - v.req;
        @(negedge clk);
        drive_req(v.req, 1'b1, v.we, v.ra1, v.ra2, v.wa, v.wd);
        #1;
        check($sformatf("v%0d accept_ready", idx), 32'(ready_of(v.req)), 32'd1);
        check($sformatf("v%0d other_ready", idx), 32'(ready_of(o)), 32'd0);
        @(negedge clk);
        #1;
        check($sformatf("v%0d ready_pulse", idx), 32'(ready_of(v.req)), 32'd0);
        drive_req(v.req, 1'b0, v.we, v.ra1, v.ra2, v.wa, v.wd);
        check($sformatf("v%0d busy", idx), 32'(bus.busy), 32'd1);
        if (v.we) begin
            check($sformatf("v%0d wr_en", idx), 32'(bus.rf_r3_wr), (v.wa != 5'd0) ? 32'd1 : 32'd0);
            check($sformatf("v%0d wr_addr", idx), 32'(bus.rf_r3_addr), 32'(v.wa));
            check($sformatf("v%0d wr_data", idx), bus.rf_r3_din, v.wd);
        end else begin
            check($sformatf("v%0d rd_wr_low", idx), 32'(bus.rf_r3_wr), 32'd0);
            check($sformatf("v%0d rd_addr1", idx), 32'(bus.rf_r1_addr), 32'(v.ra1));
            check($sformatf("v%0d rd_addr2", idx), 32'(bus.rf_r2_addr), 32'(v.ra2));
            check($sformatf("v%0d early_valid", idx), 32'(rspv_of(v.req)), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d rsp_valid", idx), 32'(rspv_of(v.req)), 32'd1);
            check($sformatf("v%0d rsp_other", idx), 32'(rspv_of(o)), 32'd0);
            check($sformatf("v%0d rd1", idx), bus.rsp_rd1, v.exp1);
            check($sformatf("v%0d rd2", idx), bus.rsp_rd2, v.exp2);
        end
        @(negedge clk);
        check($sformatf("v%0d idle_busy", idx), 32'(bus.busy), 32'd0);
        check($sformatf("v%0d idle_wr", idx), 32'(bus.rf_r3_wr), 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 1'b1, 5'd0, 5'd0, 5'd5, 32'h1234_5678, 32'h0, 32'h0};
        vecs[1] = '{0, 1'b1, 5'd0, 5'd0, 5'd6, 32'hDEAD_BEEF, 32'h0, 32'h0};
        vecs[2] = '{0, 1'b0, 5'd5, 5'd6, 5'd0, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[3] = '{1, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        vecs[4] = '{1, 1'b0, 5'd0, 5'd5, 5'd0, 32'h0, 32'h0, 32'h1234_5678};
        vecs[5] = '{1, 1'b1, 5'd0, 5'd0, 5'd9, 32'h0BAD_F00D, 32'h0, 32'h0};
        vecs[6] = '{0, 1'b0, 5'd9, 5'd6, 5'd0, 32'h0, 32'h0BAD_F00D, 32'hDEAD_BEEF};
        vecs[7] = '{1, 1'b0, 5'd6, 5'd9, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h0BAD_F00D};

        drive_req(0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        check("rst rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        check("rst r3_wr", 32'(bus.rf_r3_wr), 32'd0);
        check("rst r1_addr", 32'(bus.rf_r1_addr), 32'd0);
        check("rst r2_addr", 32'(bus.rf_r2_addr), 32'd0);
        check("rst r3_addr", 32'(bus.rf_r3_addr), 32'd0);
        check("rst r3_din", bus.rf_r3_din, 32'h0);
        check("rst req0_ready", 32'(bus.req0_ready), 32'd0);
        check("rst req1_ready", 32'(bus.req1_ready), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Response backpressure with a competing requester
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        drive_req(0, 1'b1, 1'b0, 5'd5, 5'd6, 5'd0, 32'h0);
        #1;
        check("bp accept0", 32'(bus.req0_ready), 32'd1);
        @(negedge clk);
        #1;
        drive_req(0, 1'b0, 1'b0, 5'd5, 5'd6, 5'd0, 32'h0);
        drive_req(1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd0, 32'h0);
        check("bp read_ready1", 32'(bus.req1_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp%0d rsp0_valid", k), 32'(bus.rsp0_valid), 32'd1);
            check($sformatf("bp%0d rd1", k), bus.rsp_rd1, 32'h1234_5678);
            check($sformatf("bp%0d rd2", k), bus.rsp_rd2, 32'hDEAD_BEEF);
            check($sformatf("bp%0d addr1", k), 32'(bus.rf_r1_addr), 32'd5);
            check($sformatf("bp%0d r3_wr", k), 32'(bus.rf_r3_wr), 32'd0);
            check($sformatf("bp%0d req1_ready", k), 32'(bus.req1_ready), 32'd0);
        end
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp grant1", 32'(bus.req1_ready), 32'd1);
        check("bp rsp0_dropped", 32'(bus.rsp0_valid), 32'd0);
        @(negedge clk);
        drive_req(1, 1'b0, 1'b0, 5'd6, 5'd5, 5'd0, 32'h0);
        @(negedge clk);
        check("bp rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        check("bp rsp1_rd1", bus.rsp_rd1, 32'hDEAD_BEEF);
        check("bp rsp1_rd2", bus.rsp_rd2, 32'h1234_5678);
        @(negedge clk);
        check("bp idle", 32'(bus.busy), 32'd0);

        // Tie arbitration right after reset: 0,1,0,1 every 2 cycles
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_req(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 32'h0000_0011);
        drive_req(1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd2, 32'h0000_0022);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("tie%0d ready0", k), 32'(bus.req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("tie%0d ready1", k), 32'(bus.req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            @(negedge clk);
            #1;
            check($sformatf("tie%0d wr", k), 32'(bus.rf_r3_wr), 32'd1);
            check($sformatf("tie%0d wa", k), 32'(bus.rf_r3_addr), (k % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("tie%0d gap", k), 32'(bus.req0_ready | bus.req1_ready), 32'd0);
            @(negedge clk);
        end
        drive_req(0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        v_tmp = '{1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0000_0011, 32'h0000_0022};
        run_vec(8, v_tmp);

        // Reset while a response is pending
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        drive_req(0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0);
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0);
        @(negedge clk);
        check("rr rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rr busy", 32'(bus.busy), 32'd0);
        check("rr rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        check("rr rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        check("rr r3_wr", 32'(bus.rf_r3_wr), 32'd0);
        check("rr r1_addr", 32'(bus.rf_r1_addr), 32'd0);
        check("rr r2_addr", 32'(bus.rf_r2_addr), 32'd0);
        check("rr rd1", bus.rsp_rd1, 32'h0);
        rst_n = 1'b1;
        bus.rsp0_ready = 1'b1;

        // Read-after-write tie: req0 writes r7 while req1 reads it
        drive_req(0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 32'hA5A5_A5A5);
        drive_req(1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0);
        #1;
        check("raw ready0", 32'(bus.req0_ready), 32'd1);
        check("raw ready1", 32'(bus.req1_ready), 32'd0);
        @(negedge clk);
        #1;
        check("raw wr", 32'(bus.rf_r3_wr), 32'd1);
        check("raw wa", 32'(bus.rf_r3_addr), 32'd7);
        check("raw ready1_wait", 32'(bus.req1_ready), 32'd0);
        drive_req(0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        @(negedge clk);
        #1;
        check("raw grant1", 32'(bus.req1_ready), 32'd1);
        @(negedge clk);
        drive_req(1, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0);
        @(negedge clk);
        check("raw rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        check("raw rd1", bus.rsp_rd1, 32'hA5A5_A5A5);
        check("raw rd2", bus.rsp_rd2, 32'h0);
        @(negedge clk);
        check("raw idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
